// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the five-stage MIPS pipeline.
// Optional feature: define HAZ_STALL_CNT_EN to add the stall_cycles counter output.
module pipe_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic             id_redirect,
    input  logic [REG_W-1:0] exe_rs,
    input  logic [REG_W-1:0] exe_rt,
    input  logic [REG_W-1:0] exe_wreg,
    input  logic [REG_W-1:0] mem_wreg,
    input  logic [REG_W-1:0] wb_wreg,
    input  logic             exe_regwrite,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    input  logic             exe_memread,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if2id_write,
    output logic             id2exe_write,
    output logic             exe2mem_write,
    output logic             if2id_flush,
    output logic             id2exe_bubble,
    output logic             mem2wb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
`ifdef HAZ_STALL_CNT_EN
    output logic [31:0]      stall_cycles,
`endif
    output logic [1:0]       state
);

    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, MEM_WAIT = 2'd2} state_t;

    state_t     cur, nxt;
    logic [1:0] stall_cnt, stall_cnt_nxt, stall_n;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       err_nxt;
    logic       id_exe_hit, id_mem_hit, mem_miss;

    // Register 0 is hardwired, so it can never be a real dependency.
    function automatic logic hit(input logic rw, input logic [REG_W-1:0] wreg,
                                 input logic [REG_W-1:0] src, input logic used);
        return rw && used && (wreg != '0) && (wreg == src);
    endfunction

    assign id_exe_hit = hit(exe_regwrite, exe_wreg, id_rs, id_use_rs) |
                        hit(exe_regwrite, exe_wreg, id_rt, id_use_rt);
    assign id_mem_hit = hit(mem_regwrite, mem_wreg, id_rs, id_use_rs) |
                        hit(mem_regwrite, mem_wreg, id_rt, id_use_rt);
    assign mem_miss   = mem_access && !mem_ready;
    assign state      = cur;

    // Branches compare in ID, so a load feeding one needs two bubbles; the 2 case is last so it wins.
    always_comb begin
        stall_n = 2'd0;
        if (exe_memread && id_exe_hit)                 stall_n = 2'd1;
        if (id_branch && !exe_memread && id_exe_hit)   stall_n = 2'd1;
        if (id_branch && id_mem_hit)                   stall_n = 2'd1;
        if (id_branch && exe_memread && id_exe_hit)    stall_n = 2'd2;
    end

    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        if (hit(mem_regwrite, mem_wreg, exe_rs, 1'b1))     fwd_a = 2'd1;
        else if (hit(wb_regwrite, wb_wreg, exe_rs, 1'b1))  fwd_a = 2'd2;
        if (hit(mem_regwrite, mem_wreg, exe_rt, 1'b1))     fwd_b = 2'd1;
        else if (hit(wb_regwrite, wb_wreg, exe_rt, 1'b1))  fwd_b = 2'd2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= RUN;
            stall_cnt <= 2'd0;
            wait_cnt  <= 8'd0;
            mem_err   <= 1'b0;
        end else begin
            cur       <= nxt;
            stall_cnt <= stall_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_err   <= err_nxt;
        end
    end

    always_comb begin
        nxt           = cur;
        stall_cnt_nxt = stall_cnt;
        wait_cnt_nxt  = wait_cnt;
        err_nxt       = mem_err;
        case (cur)
            RUN: begin
                if (mem_miss) begin
                    nxt          = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end else if (stall_n != 2'd0) begin
                    nxt           = STALL;
                    stall_cnt_nxt = stall_n - 2'd1;
                end
            end
            STALL: begin
                if (stall_cnt == 2'd0) nxt = RUN;
                else                   stall_cnt_nxt = stall_cnt - 2'd1;
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    nxt = RUN;
                end else if (wait_cnt >= 8'(MEM_TIMEOUT)) begin
                    nxt     = RUN;
                    err_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            default: nxt = RUN;
        endcase
    end

    always_comb begin
        pc_write      = 1'b1;
        if2id_write   = 1'b1;
        id2exe_write  = 1'b1;
        exe2mem_write = 1'b1;
        if2id_flush   = 1'b0;
        id2exe_bubble = 1'b0;
        mem2wb_bubble = 1'b0;
        case (cur)
            RUN: begin
                if (!mem_miss) begin
                    if (stall_n != 2'd0) begin
                        pc_write      = 1'b0;
                        if2id_write   = 1'b0;
                        id2exe_bubble = 1'b1;
                    end else if (id_redirect) begin
                        if2id_flush = 1'b1;
                    end
                end
            end
            STALL: begin
                pc_write      = 1'b0;
                if2id_write   = 1'b0;
                id2exe_bubble = 1'b1;
            end
            MEM_WAIT: begin
                pc_write      = 1'b0;
                if2id_write   = 1'b0;
                id2exe_write  = 1'b0;
                exe2mem_write = 1'b0;
                mem2wb_bubble = !mem_ready;
            end
            default: ;
        endcase
    end

`ifdef HAZ_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= 32'd0;
        else if ((cur == STALL || cur == MEM_WAIT) && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; expected output vectors are queued per cycle.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, exe_rs, exe_rt, exe_wreg, mem_wreg, wb_wreg;
    logic       id_use_rs, id_use_rt, id_branch, id_redirect;
    logic       exe_regwrite, mem_regwrite, wb_regwrite, exe_memread, mem_access, mem_ready;
    logic       pc_write, if2id_write, id2exe_write, exe2mem_write;
    logic       if2id_flush, id2exe_bubble, mem2wb_bubble, mem_err;
    logic [1:0] fwd_a, fwd_b, state;
`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    pipe_hazard_ctrl #(.REG_W(5), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_redirect(id_redirect), .exe_rs(exe_rs), .exe_rt(exe_rt),
        .exe_wreg(exe_wreg), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
        .exe_regwrite(exe_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .exe_memread(exe_memread), .mem_access(mem_access), .mem_ready(mem_ready),
        .pc_write(pc_write), .if2id_write(if2id_write), .id2exe_write(id2exe_write),
        .exe2mem_write(exe2mem_write), .if2id_flush(if2id_flush),
        .id2exe_bubble(id2exe_bubble), .mem2wb_bubble(mem2wb_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
`ifdef HAZ_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    int          errors = 0, checks = 0, exp_stall = 0;
    logic        exp_err = 1'b0;
    logic [13:0] sb[$];

    localparam logic [3:0] EN_ALL = 4'b1111, EN_STL = 4'b0011, EN_WT = 4'b0000;

    // {state, mem_err, pc/if2id/id2exe/exe2mem write, flush, id2exe_bubble, mem2wb_bubble, fwd_a, fwd_b}
    function automatic logic [13:0] ex(input logic [1:0] st, input logic [3:0] en, input logic fl,
                                       input logic idb, input logic mwb, input logic [1:0] fa,
                                       input logic [1:0] fb);
        return {st, exp_err, en, fl, idb, mwb, fa, fb};
    endfunction

    function automatic logic [13:0] obs();
        return {state, mem_err, pc_write, if2id_write, id2exe_write, exe2mem_write,
                if2id_flush, id2exe_bubble, mem2wb_bubble, fwd_a, fwd_b};
    endfunction

    task automatic push(input logic [13:0] e);
        sb.push_back(e);
        if (e[13:12] != 2'd0) exp_stall++;
    endtask

    task automatic clear_in();
        {id_rs, id_rt, exe_rs, exe_rt, exe_wreg, mem_wreg, wb_wreg} = '0;
        {id_use_rs, id_use_rt, id_branch, id_redirect} = '0;
        {exe_regwrite, mem_regwrite, wb_regwrite, exe_memread, mem_access, mem_ready} = '0;
    endtask

    task automatic test_reset();
        logic [13:0] got, want;
        rst = 1'b1;
        clear_in();
        push(ex(2'd0, EN_ALL, 0, 0, 0, 2'd0, 2'd0));
        @(negedge clk);
        got = obs(); want = sb.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL reset: got %b want %b", got, want); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [4:0] ers, ert, mw, ww;
        logic       mrw, wrw;
        logic [1:0] fa, fb;
    } fw_t;

    task automatic test_forwarding();
        fw_t tbl[6];
        logic [13:0] got, want;
        tbl = '{'{5'd5, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 2'd1, 2'd0},
                '{5'd5, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 2'd2, 2'd0},
                '{5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 2'd0, 2'd0},
                '{5'd9, 5'd5, 5'd9, 5'd5, 1'b1, 1'b1, 2'd1, 2'd2},
                '{5'd3, 5'd3, 5'd3, 5'd4, 1'b0, 1'b1, 2'd0, 2'd0},
                '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0}};
        for (int i = 0; i < 6; i++) begin
            clear_in();
            exe_rs = tbl[i].ers; exe_rt = tbl[i].ert;
            mem_wreg = tbl[i].mw; wb_wreg = tbl[i].ww;
            mem_regwrite = tbl[i].mrw; wb_regwrite = tbl[i].wrw;
            push(ex(2'd0, EN_ALL, 0, 0, 0, tbl[i].fa, tbl[i].fb));
            @(negedge clk);
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL fwd[%0d]: got %b want %b", i, got, want); end
            @(posedge clk); #1;
        end
        clear_in();
    endtask

    typedef struct {
        logic [4:0] rs, rt, ew, mw;
        logic       urs, urt, br, erw, emr, mrw;
        int         n;
    } hz_t;

    task automatic test_stall();
        hz_t tbl[9];
        logic [13:0] got, want;
        tbl = '{'{5'd2, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1},  // load-use
                '{5'd0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2},  // branch on load
                '{5'd4, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1},  // branch on EXE alu
                '{5'd0, 5'd6, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1},  // branch on MEM writer
                '{5'd7, 5'd0, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2},  // max wins
                '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0},  // $0 never hazards
                '{5'd2, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0},  // source unused
                '{5'd4, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0},  // alu, no branch
                '{5'd6, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0}}; // MEM no regwrite
        for (int i = 0; i < 9; i++) begin
            clear_in();
            id_rs = tbl[i].rs; id_rt = tbl[i].rt; id_use_rs = tbl[i].urs; id_use_rt = tbl[i].urt;
            id_branch = tbl[i].br; exe_wreg = tbl[i].ew; exe_regwrite = tbl[i].erw;
            exe_memread = tbl[i].emr; mem_wreg = tbl[i].mw; mem_regwrite = tbl[i].mrw;
            if (tbl[i].n > 0) push(ex(2'd0, EN_STL, 0, 1, 0, 2'd0, 2'd0));
            else              push(ex(2'd0, EN_ALL, 0, 0, 0, 2'd0, 2'd0));
            @(negedge clk);
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL stall[%0d] detect: got %b want %b", i, got, want); end
            @(posedge clk); #1;
            clear_in();
            id_redirect = 1'b1;
            for (int k = 0; k < tbl[i].n; k++) begin
                push(ex(2'd1, EN_STL, 0, 1, 0, 2'd0, 2'd0));
                @(negedge clk);
                got = obs(); want = sb.pop_front(); checks++;
                if (got !== want) begin errors++; $display("FAIL stall[%0d] hold%0d: got %b want %b", i, k, got, want); end
                @(posedge clk); #1;
            end
            id_redirect = 1'b0;
            push(ex(2'd0, EN_ALL, 0, 0, 0, 2'd0, 2'd0));
            @(negedge clk);
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL stall[%0d] resume: got %b want %b", i, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        logic [13:0] got, want;
        for (int c = 0; c < 5; c++) begin
            clear_in();
            case (c)
                0: begin id_redirect = 1'b1; push(ex(2'd0, EN_ALL, 1, 0, 0, 2'd0, 2'd0)); end
                1: push(ex(2'd0, EN_ALL, 0, 0, 0, 2'd0, 2'd0));
                2: begin
                    id_redirect = 1'b1; id_rs = 5'd8; id_use_rs = 1'b1;
                    exe_wreg = 5'd8; exe_regwrite = 1'b1; exe_memread = 1'b1;
                    push(ex(2'd0, EN_STL, 0, 1, 0, 2'd0, 2'd0));
                end
                3: push(ex(2'd1, EN_STL, 0, 1, 0, 2'd0, 2'd0));
                default: push(ex(2'd0, EN_ALL, 0, 0, 0, 2'd0, 2'd0));
            endcase
            @(negedge clk);
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL redirect c%0d: got %b want %b", c, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        logic [13:0] got, want;
        for (int c = 0; c < 7; c++) begin
            clear_in();
            if (c < 5) begin
                id_rs = 5'd2; id_use_rs = 1'b1; exe_wreg = 5'd2; exe_regwrite = 1'b1; exe_memread = 1'b1;
            end
            mem_access = (c < 4);
            mem_ready  = (c == 3);
            case (c)
                0:       push(ex(2'd0, EN_ALL, 0, 0, 0, 2'd0, 2'd0));
                1, 2:    push(ex(2'd2, EN_WT,  0, 0, 1, 2'd0, 2'd0));
                3:       push(ex(2'd2, EN_WT,  0, 0, 0, 2'd0, 2'd0));
                4:       push(ex(2'd0, EN_STL, 0, 1, 0, 2'd0, 2'd0));
                5:       push(ex(2'd1, EN_STL, 0, 1, 0, 2'd0, 2'd0));
                default: push(ex(2'd0, EN_ALL, 0, 0, 0, 2'd0, 2'd0));
            endcase
            @(negedge clk);
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL mem_wait c%0d: got %b want %b", c, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        logic [13:0] got, want;
        for (int c = 0; c < 21; c++) begin
            clear_in();
            mem_access = (c < 16) || (c == 20);
            mem_ready  = (c == 20);
            if (c == 16) exp_err = 1'b1;
            if (c >= 1 && c <= 15) push(ex(2'd2, EN_WT,  0, 0, 1, 2'd0, 2'd0));
            else                   push(ex(2'd0, EN_ALL, 0, 0, 0, 2'd0, 2'd0));
            @(negedge clk);
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL timeout c%0d: got %b want %b", c, got, want); end
            @(posedge clk); #1;
        end
        clear_in();
    endtask

    task automatic test_stall_count();
`ifdef HAZ_STALL_CNT_EN
        @(negedge clk);
        checks++;
        if (stall_cycles !== 32'(exp_stall)) begin
            errors++;
            $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, exp_stall);
        end
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_reset_mid();
        logic [13:0] got, want;
        for (int s = 0; s < 2; s++) begin
            clear_in();
            if (s == 0) begin
                mem_access = 1'b1;
            end else begin
                id_rt = 5'd3; id_use_rt = 1'b1; id_branch = 1'b1;
                exe_wreg = 5'd3; exe_regwrite = 1'b1; exe_memread = 1'b1;
            end
            @(posedge clk); #1;
            clear_in();
            mem_access = (s == 0);
            rst = 1'b1;
            exp_err = 1'b0;
            push(ex(2'd0, EN_ALL, 0, 0, 0, 2'd0, 2'd0));
            #1;
            got = obs(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL reset_mid[%0d]: got %b want %b", s, got, want); end
            @(posedge clk); #1;
            rst = 1'b0;
        end
        clear_in();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_forwarding();
        test_stall();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_stall_count();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
